// File: rtl/window_gen_3x3.sv
// Streaming 3x3 sliding-window generator: two row buffers plus a 3x3 shift window.
// One window is emitted per accepted pixel once the pixel is at row >= 2 and col >= 2.
module window_gen_3x3 #(
  parameter int unsigned IMG_W = 28,
  parameter int unsigned IMG_H = 28
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pixel_valid,
  input  logic [31:0] pixel_in,
  output logic        window_valid,
  output logic [31:0] W_1,
  output logic [31:0] W_2,
  output logic [31:0] W_3,
  output logic [31:0] W_4,
  output logic [31:0] W_5,
  output logic [31:0] W_6,
  output logic [31:0] W_7,
  output logic [31:0] W_8,
  output logic [31:0] W_9,
  output logic        frame_done
);

  localparam int unsigned CW = (IMG_W > 4) ? $clog2(IMG_W) : 2;
  localparam int unsigned RW = (IMG_H > 4) ? $clog2(IMG_H) : 2;

  localparam logic [CW-1:0] COL_ZERO = CW'(0);
  localparam logic [CW-1:0] COL_ONE  = CW'(1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_ZERO = RW'(0);
  localparam logic [RW-1:0] ROW_ONE  = RW'(1);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic [CW-1:0] col_r;
  logic [RW-1:0] row_r;
  logic [31:0]   line1_r [IMG_W];
  logic [31:0]   line2_r [IMG_W];
  logic [31:0]   win_r   [9];
  logic          window_valid_r;
  logic          frame_done_r;

  logic [31:0]   top_s;
  logic [31:0]   mid_s;
  logic          col_last_s;
  logic          row_last_s;
  logic          win_pos_s;

  // Buffer taps at the current column and position decode
  always_comb begin
    top_s      = line2_r[col_r];
    mid_s      = line1_r[col_r];
    col_last_s = (col_r == COL_LAST);
    row_last_s = (row_r == ROW_LAST);
    win_pos_s  = (col_r >= COL_TWO) && (row_r >= ROW_TWO);
  end

  // Raster position counters, wrapping at row and frame end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_r <= COL_ZERO;
      row_r <= ROW_ZERO;
    end else if (pixel_valid) begin
      if (col_last_s) begin
        col_r <= COL_ZERO;
        if (row_last_s) begin
          row_r <= ROW_ZERO;
        end else begin
          row_r <= row_r + ROW_ONE;
        end
      end else begin
        col_r <= col_r + COL_ONE;
      end
    end
  end

  // Row buffers are deliberately unreset; windows only read rows written this frame
  always_ff @(posedge clk) begin
    if (pixel_valid) begin
      line2_r[col_r] <= line1_r[col_r];
      line1_r[col_r] <= pixel_in;
    end
  end

  // 3x3 shift window: each row moves left, new right column enters from buffers and input
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < 9; k++) begin
        win_r[k] <= 32'd0;
      end
    end else if (pixel_valid) begin
      for (int i = 0; i < 3; i++) begin
        win_r[3*i]   <= win_r[3*i+1];
        win_r[3*i+1] <= win_r[3*i+2];
      end
      win_r[2] <= top_s;
      win_r[5] <= mid_s;
      win_r[8] <= pixel_in;
    end
  end

  // Single-cycle strobes, one per accepted pixel, never held over idle cycles
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      window_valid_r <= 1'b0;
      frame_done_r   <= 1'b0;
    end else begin
      window_valid_r <= pixel_valid && win_pos_s;
      frame_done_r   <= pixel_valid && col_last_s && row_last_s;
    end
  end

  assign window_valid = window_valid_r;
  assign frame_done   = frame_done_r;
  assign W_1 = win_r[0];
  assign W_2 = win_r[1];
  assign W_3 = win_r[2];
  assign W_4 = win_r[3];
  assign W_5 = win_r[4];
  assign W_6 = win_r[5];
  assign W_7 = win_r[6];
  assign W_8 = win_r[7];
  assign W_9 = win_r[8];

endmodule

// File: tb/tb_window_gen_3x3.sv
// Scoreboard bench for window_gen_3x3: a 4x4 instance for the directed scenarios
// and a default 28x28 instance for the full-size frame.
module tb_window_gen_3x3;

  typedef struct {
    logic [287:0] w;
    logic         fd;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        pv_s, pv_b;
  logic [31:0] px_s, px_b;
  logic        wv_s, fd_s, wv_b, fd_b;
  logic [31:0] ws [9];
  logic [31:0] wb [9];
  logic [287:0] obs_s, obs_b, last_s;

  assign obs_s = {ws[0], ws[1], ws[2], ws[3], ws[4], ws[5], ws[6], ws[7], ws[8]};
  assign obs_b = {wb[0], wb[1], wb[2], wb[3], wb[4], wb[5], wb[6], wb[7], wb[8]};

  window_gen_3x3 #(.IMG_W(4), .IMG_H(4)) u_small (
    .clk(clk), .rst(rst), .pixel_valid(pv_s), .pixel_in(px_s), .window_valid(wv_s),
    .W_1(ws[0]), .W_2(ws[1]), .W_3(ws[2]), .W_4(ws[3]), .W_5(ws[4]),
    .W_6(ws[5]), .W_7(ws[6]), .W_8(ws[7]), .W_9(ws[8]), .frame_done(fd_s)
  );

  window_gen_3x3 #(.IMG_W(28), .IMG_H(28)) u_big (
    .clk(clk), .rst(rst), .pixel_valid(pv_b), .pixel_in(px_b), .window_valid(wv_b),
    .W_1(wb[0]), .W_2(wb[1]), .W_3(wb[2]), .W_4(wb[3]), .W_5(wb[4]),
    .W_6(wb[5]), .W_7(wb[6]), .W_8(wb[7]), .W_9(wb[8]), .frame_done(fd_b)
  );

  int   errors = 0;
  int   checks = 0;
  exp_t q_s[$];
  exp_t q_b[$];
  int   cyc = 0;
  int   win_cnt_s = 0;
  int   win_cnt_b = 0;
  int   first_cyc_b = 0;
  int   pres_cyc_b = 0;
  bit   seen_first_b = 1'b0;
  bit   hold_chk = 1'b0;
  logic pv_s_edge = 1'b0;

  task automatic check_eq(input string tag, input logic [287:0] obs, input logic [287:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference window built from pixel coordinates: value = base + row*wid + col
  function automatic logic [287:0] win_of(input int base, input int wid, input int r, input int c);
    logic [287:0] v;
    v = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        v[287-32*(3*i+j) -: 32] = 32'(base + (r - 2 + i) * wid + (c - 2 + j));
      end
    end
    return v;
  endfunction

  task automatic send_s(input int base, input int idx, input int gap);
    int   r, c;
    exp_t e;
    r = idx / 4;
    c = idx % 4;
    px_s = 32'(base + idx);
    pv_s = 1'b1;
    if (r >= 2 && c >= 2) begin
      e.w  = win_of(base, 4, r, c);
      e.fd = (r == 3 && c == 3);
      q_s.push_back(e);
    end
    @(posedge clk); #1;
    pv_s = 1'b0;
    repeat (gap) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_b(input int base, input int idx);
    int   r, c;
    exp_t e;
    r = idx / 28;
    c = idx % 28;
    px_b = 32'(base + idx);
    pv_b = 1'b1;
    if (idx == 58) pres_cyc_b = cyc;
    if (r >= 2 && c >= 2) begin
      e.w  = win_of(base, 28, r, c);
      e.fd = (r == 27 && c == 27);
      q_b.push_back(e);
    end
    @(posedge clk); #1;
    pv_b = 1'b0;
  endtask

  always @(posedge clk) begin
    cyc++;
    pv_s_edge = pv_s;
  end

  // Small-instance monitor: pop and compare on each window, idle checks otherwise
  always @(negedge clk) begin
    exp_t e;
    if (wv_s) begin
      win_cnt_s++;
      if (q_s.size() == 0) begin
        check_eq("s_unexpected_window", 1'b1, 1'b0);
      end else begin
        e = q_s.pop_front();
        check_eq("s_window", obs_s, e.w);
        check_eq("s_frame_done", fd_s, e.fd);
      end
    end else begin
      check_eq("s_frame_done_idle", fd_s, 1'b0);
      if (hold_chk && !pv_s_edge) check_eq("s_hold", obs_s, last_s);
    end
    last_s = obs_s;
  end

  // Big-instance monitor
  always @(negedge clk) begin
    exp_t e;
    if (wv_b) begin
      win_cnt_b++;
      if (!seen_first_b) begin
        seen_first_b = 1'b1;
        first_cyc_b  = cyc;
      end
      if (q_b.size() == 0) begin
        check_eq("b_unexpected_window", 1'b1, 1'b0);
      end else begin
        e = q_b.pop_front();
        check_eq("b_window", obs_b, e.w);
        check_eq("b_frame_done", fd_b, e.fd);
      end
    end else begin
      check_eq("b_frame_done_idle", fd_b, 1'b0);
    end
  end

  initial begin
    int c0;
    rst  = 1'b0;
    pv_s = 1'b0;
    pv_b = 1'b0;
    px_s = 32'd0;
    px_b = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_w_small", obs_s, 288'd0);
    check_eq("reset_wv_small", wv_s, 1'b0);
    check_eq("reset_fd_small", fd_s, 1'b0);
    check_eq("reset_w_big", obs_b, 288'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Tests 1/2: continuous 4x4 frame
    c0 = win_cnt_s;
    for (int i = 0; i < 16; i++) send_s(0, i, 0);
    repeat (3) begin @(posedge clk); #1; end
    check_eq("t1_window_count", 32'(win_cnt_s - c0), 32'd4);
    check_eq("t1_queue_drained", 32'(q_s.size()), 32'd0);

    // Test 3: three idle cycles between pixels, outputs must hold
    hold_chk = 1'b1;
    c0 = win_cnt_s;
    for (int i = 0; i < 16; i++) send_s(0, i, 3);
    repeat (3) begin @(posedge clk); #1; end
    hold_chk = 1'b0;
    check_eq("t3_window_count", 32'(win_cnt_s - c0), 32'd4);
    check_eq("t3_queue_drained", 32'(q_s.size()), 32'd0);

    // Test 4: back-to-back frames, second offset by 100
    c0 = win_cnt_s;
    for (int i = 0; i < 16; i++) send_s(0, i, 0);
    for (int i = 0; i < 16; i++) send_s(100, i, 0);
    repeat (3) begin @(posedge clk); #1; end
    check_eq("t4_window_count", 32'(win_cnt_s - c0), 32'd8);
    check_eq("t4_queue_drained", 32'(q_s.size()), 32'd0);

    // Test 5: asynchronous reset after pixel 6, between clock edges
    for (int i = 0; i < 7; i++) send_s(0, i, 0);
    #2;
    rst = 1'b0;
    #1;
    check_eq("t5_reset_w", obs_s, 288'd0);
    check_eq("t5_reset_wv", wv_s, 1'b0);
    check_eq("t5_reset_fd", fd_s, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    c0 = win_cnt_s;
    for (int i = 0; i < 16; i++) send_s(0, i, 0);
    repeat (3) begin @(posedge clk); #1; end
    check_eq("t5_window_count", 32'(win_cnt_s - c0), 32'd4);
    check_eq("t5_queue_drained", 32'(q_s.size()), 32'd0);

    // Test 6: default-size continuous frame
    c0 = win_cnt_b;
    for (int i = 0; i < 784; i++) send_b(1000, i);
    repeat (3) begin @(posedge clk); #1; end
    check_eq("t6_window_count", 32'(win_cnt_b - c0), 32'd676);
    check_eq("t6_first_window_latency", 32'(first_cyc_b - pres_cyc_b), 32'd1);
    check_eq("t6_queue_drained", 32'(q_b.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/window_gen_3x3.md
# window_gen_3x3

Streaming 3x3 sliding-window generator that sits directly upstream of the nine-input FP32 summation stage in the convolution datapath. It accepts one 32-bit pixel per valid cycle in raster order, buffers the two previous image rows internally, and emits the full 3x3 neighbourhood (W_1..W_9) with a single-cycle valid strobe. The outputs are shaped to drive the summer's IN_1..IN_9 / input_valid inputs directly. The block is data-agnostic: words are passed through bit-exact with no arithmetic.

## Interface
- IMG_W, 28: image width in pixels (>= 3)
- IMG_H, 28: image height in rows (>= 3)
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset (0 = reset)
- pixel_valid  input  1  pixel_in is valid this cycle
- pixel_in  input  32  pixel word, raster order (row-major, col 0 first)
- window_valid  output  1  W_1..W_9 hold a new window this cycle
- W_1 .. W_9  output  32 each  window, row-major: W_1 = (r-2,c-2), W_2 = (r-2,c-1), W_3 = (r-2,c), W_4..W_6 = row r-1, W_7..W_9 = row r
- frame_done  output  1  one-cycle pulse coincident with the last window of a frame

## Operation
- Column counter col (0..IMG_W-1) and row counter row (0..IMG_H-1) advance only on accepted pixels (pixel_valid=1).
- Wrap rules: at col = IMG_W-1, col returns to 0 and row increments. At row = IMG_H-1 and col = IMG_W-1, both return to 0 and the next pixel starts a new frame.
- Line buffers: two IMG_W-deep 32-bit row memories, indexed by col.
  - On each accepted pixel, the buffer slot at col is shifted: row r-2 takes row r-1, and row r-1 takes pixel_in.
  - Buffer contents are not reset. Windows are only emitted once both rows have been written in the current frame, so stale contents are never exposed.
- Shift window: a 3x3 register array.
  - On each accepted pixel, each row shifts left one column.
  - New right column: {line r-2 [col], line r-1 [col], pixel_in}.
- Window valid condition: accepted pixel with row >= 2 and col >= 2. No padding; a frame produces (IMG_W-2)*(IMG_H-2) windows.
- Windows never straddle a row boundary. Columns 0 and 1 of each row only refill the shift window.
- frame_done is asserted with the window produced by pixel (IMG_H-1, IMG_W-1).
- Idle (pixel_valid=0):
  - Counters, buffers and the shift window hold.
  - window_valid=0 and frame_done=0.
  - W_1..W_9 hold their last value.

## Timing
- Reset (rst=0, asynchronous): window_valid=0, frame_done=0, W_1..W_9=32'd0, col=0, row=0. Takes effect immediately, regardless of clk.
- Reset mid-frame: the partial frame is discarded. The first pixel after reset release is treated as (0,0).
- Latency: pixel accepted on edge N. The corresponding window_valid / W / frame_done are registered and visible after edge N+1, i.e. one cycle of latency.
- Throughput: one window per cycle when pixel_valid is held high.
- No backpressure: the downstream summer must accept every window_valid cycle.
- window_valid and frame_done are single-cycle strobes per accepted pixel. They are never stretched across idle cycles.
- Back-to-back frames: no idle cycle is required between the last pixel of frame k and the first pixel of frame k+1.

## Test plan
- Test 1, first window (IMG_W=4, IMG_H=4, pixel value = r*4+c, pixel_valid held high):
  - No window_valid for pixels 0..9.
  - The cycle after pixel 10: window_valid=1, W_1..W_9 = 0,1,2,4,5,6,8,9,10.
  - Windows follow for pixels 11, 14 and 15: 4 windows total.
- Test 2, last window (same stream): pixel 15 -> W = 5,6,7,9,10,11,13,14,15 with frame_done=1 in the same cycle. frame_done is 0 on all other cycles.
- Test 3, gapped input: same stream with pixel_valid deasserted for 3 cycles between every pixel -> identical window sequence and values. window_valid is 1 for exactly one cycle per window, and W holds during gaps.
- Test 4, back-to-back frames: two 4x4 frames with no gap, second frame values +100 -> second frame's first window is 100,101,102,104,105,106,108,109,110, with no window emitted for second-frame pixels 100..109.
- Test 5, reset mid-frame: assert rst=0 asynchronously (between clk edges) after pixel 6 -> all outputs go to 0 immediately. After release, a fresh 4x4 frame yields exactly 4 windows, the first being 0,1,2,4,5,6,8,9,10.
- Test 6, default size (IMG_W=28, IMG_H=28, continuous stream) -> exactly 676 window_valid pulses, frame_done on the 676th, and the first window appears 1 cycle after pixel index 58.
